// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared widths, defaults and serializer state type for the systolic array slice
package systolic_pkg;

   localparam int SYS_DATA_WIDTH = 8;
   localparam int SYS_SIZE       = 16;
   localparam int SYS_DEPTH      = 4;

   localparam int IDX_W = $clog2(SYS_SIZE);
   localparam int CNT_W = $clog2(SYS_DEPTH + 1);

   typedef enum logic {IDLE, STREAM} ser_state_t;

endpackage

// File: rtl/vec_fifo.sv
// rtl/vec_fifo.sv - DEPTH-entry wide-word FIFO exposing the head entry, full/empty and occupancy
module vec_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is data-only; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - buffers packed result vectors and emits them one element per beat
// Optional parity outputs and per-entry parity storage: RESULT_SERIALIZER_PARITY_EN
module result_serializer
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = SYS_DATA_WIDTH,
   parameter int SIZE       = SYS_SIZE,
   parameter int DEPTH      = SYS_DEPTH
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH*SIZE-1:0]   in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [$clog2(SIZE)-1:0]      out_index,
   output logic                         out_last,
`ifdef RESULT_SERIALIZER_PARITY_EN
   output logic                         out_parity,
   output logic                         vec_parity_err,
`endif
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int EW = $clog2(SIZE);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int VW = DATA_WIDTH * SIZE;
`ifdef RESULT_SERIALIZER_PARITY_EN
   localparam int FW = VW + 1;
`else
   localparam int FW = VW;
`endif

   ser_state_t          state_q, state_d;
   logic [EW-1:0]       elem_idx_q, elem_idx_d;
   logic [FW-1:0]       fifo_wdata, fifo_head;
   logic [DATA_WIDTH-1:0] elem;
   logic [CW-1:0]       fifo_count;
   logic                fifo_full, fifo_empty;
   logic                push, pop, pop_last;

   assign push     = in_valid && !fifo_full;
   assign pop      = out_valid && out_ready;
   assign pop_last = pop && (elem_idx_q == EW'(SIZE - 1));

`ifdef RESULT_SERIALIZER_PARITY_EN
   assign fifo_wdata = {^in_data, in_data};
`else
   assign fifo_wdata = in_data;
`endif

   vec_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (fifo_wdata),
      .pop     (pop_last && !fifo_empty),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign elem = fifo_head[DATA_WIDTH*elem_idx_q +: DATA_WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         elem_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         elem_idx_q <= elem_idx_d;
      end
   end

   // Leave STREAM only when the last held vector finishes and nothing new arrives.
   always_comb begin
      state_d    = state_q;
      elem_idx_d = elem_idx_q;
      case (state_q)
         IDLE:   if (push) state_d = STREAM;
         STREAM: if (pop_last && fifo_count == CW'(1) && !push) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (pop_last)  elem_idx_d = '0;
      else if (pop)  elem_idx_d = elem_idx_q + 1'b1;
   end

   always_comb begin
      out_valid = (state_q == STREAM);
      out_data  = out_valid ? elem : '0;
      out_index = elem_idx_q;
      out_last  = out_valid && (elem_idx_q == EW'(SIZE - 1));
      in_ready  = !fifo_full;
      count     = fifo_count;
   end

`ifdef RESULT_SERIALIZER_PARITY_EN
   logic sent_par_q, sent_par_d;

   always_comb begin
      sent_par_d = sent_par_q;
      if (pop_last) sent_par_d = 1'b0;
      else if (pop) sent_par_d = sent_par_q ^ (^elem);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sent_par_q <= 1'b0;
      else          sent_par_q <= sent_par_d;
   end

   assign out_parity     = ^out_data;
   assign vec_parity_err = pop_last && ((sent_par_q ^ (^elem)) != fifo_head[VW]);
`endif

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - scoreboard bench for result_serializer; parity checks under RESULT_SERIALIZER_PARITY_EN
module tb_result_serializer;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic [3:0]   out_index;
   logic         out_last;
   logic [2:0]   count;
`ifdef RESULT_SERIALIZER_PARITY_EN
   logic         out_parity;
   logic         vec_parity_err;
`endif

   typedef struct {
      logic [7:0] data;
      logic [3:0] idx;
      logic       last;
      logic       perr;
   } beat_t;

   beat_t sbq[$];
   int checks   = 0;
   int failures = 0;

   result_serializer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_index      (out_index),
      .out_last       (out_last),
`ifdef RESULT_SERIALIZER_PARITY_EN
      .out_parity     (out_parity),
      .vec_parity_err (vec_parity_err),
`endif
      .count          (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] mkvec(input logic [7:0] base);
      logic [127:0] v;
      for (int t = 0; t < 16; t++) v[8*t +: 8] = base + 8'(t);
      return v;
   endfunction

   task automatic expect_vec(input logic [127:0] v);
      beat_t b;
      for (int t = 0; t < 16; t++) begin
         b.data = v[8*t +: 8];
         b.idx  = 4'(t);
         b.last = (t == 15);
         b.perr = 1'b0;
         sbq.push_back(b);
      end
   endtask

   task automatic push_vec(input logic [127:0] v);
      int n = 0;
      in_data  = v;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 300);
      if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_vec(v);
   endtask

   task automatic wait_idx(input logic [3:0] idx);
      int n = 0;
      while (!(out_valid && out_index == idx) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!(out_valid && out_index == idx)) chk("wait_idx_timeout", 32'(out_index), 32'(idx));
   endtask

   task automatic wait_empty();
      int n = 0;
      while ((sbq.size() != 0 || count != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_sb_left", 32'(sbq.size()), 32'd0);
      chk("drain_count", 32'(count), 32'd0);
   endtask

   always @(negedge clk) begin : monitor
      beat_t e;
      if (reset_n && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            e = sbq.pop_front();
            chk("beat_data", 32'(out_data), 32'(e.data));
            chk("beat_index", 32'(out_index), 32'(e.idx));
            chk("beat_last", 32'(out_last), 32'(e.last));
`ifdef RESULT_SERIALIZER_PARITY_EN
            chk("beat_parity", 32'(out_parity), 32'(^e.data));
            chk("beat_perr", 32'(vec_parity_err), 32'(e.perr));
`endif
         end
      end
   end

   initial begin
      int nv;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Single vector, sink always ready: 16 back-to-back beats
      out_ready = 1'b1;
      push_vec(mkvec(8'h00));
      nv = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      chk("consec_valid", 32'(nv), 32'd16);
      @(negedge clk);
      chk("after_vec_valid", 32'(out_valid), 32'd0);
      chk("after_vec_count", 32'(count), 32'd0);

      // Stall on the first beat
      @(posedge clk); #1;
      out_ready = 1'b0;
      push_vec(mkvec(8'hA0));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_data", 32'(out_data), 32'hA0);
         chk("stall_index", 32'(out_index), 32'd0);
         chk("stall_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_empty();

      // Fill to DEPTH with the sink stalled; a fifth vector is refused
      @(posedge clk); #1;
      out_ready = 1'b0;
      push_vec(mkvec(8'hB0));
      push_vec(mkvec(8'hC0));
      push_vec(mkvec(8'hD0));
      push_vec(mkvec(8'hE0));
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_data  = mkvec(8'hF0);
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("full_ignored_count", 32'(count), 32'd4);
      out_ready = 1'b1;
      wait_empty();

      // Push colliding with the final-element pop, at count 4 and then count 3
      @(posedge clk); #1;
      out_ready = 1'b0;
      push_vec(mkvec(8'h10));
      push_vec(mkvec(8'h20));
      push_vec(mkvec(8'h30));
      push_vec(mkvec(8'h40));
      out_ready = 1'b1;
      wait_idx(4'd15);
      chk("collide_full_ready", 32'(in_ready), 32'd0);
      in_data  = mkvec(8'h50);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("collide_full_count", 32'(count), 32'd3);
      wait_idx(4'd15);
      chk("collide_3_ready", 32'(in_ready), 32'd1);
      in_data  = mkvec(8'h60);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_vec(mkvec(8'h60));
      chk("collide_3_count", 32'(count), 32'd3);
      wait_empty();

      // Asynchronous reset in the middle of a vector
      @(posedge clk); #1;
      push_vec(mkvec(8'h70));
      wait_idx(4'd7);
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_index", 32'(out_index), 32'd0);
      sbq.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      push_vec(mkvec(8'h80));
      wait_empty();

`ifdef RESULT_SERIALIZER_PARITY_EN
      // Parity: clean vector, then a vector corrupted in storage (entry 1 after reset)
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n   = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      push_vec(128'h1);
      push_vec(mkvec(8'h90));
      dut.u_fifo.mem_q[1][24] = ~dut.u_fifo.mem_q[1][24];
      sbq[19].data = sbq[19].data ^ 8'h01;
      sbq[31].perr = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_empty();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
